// File: rtl/pwm_capture_ctrl.sv
// Trigger/wait/read/clear sequencer for one PWM capture core.
// Define PWM_CAPTURE_AVG_EN to report the average of four captures.
module pwm_capture_ctrl #(
    parameter int unsigned INTERVAL = 100000,
    parameter int unsigned TIMEOUT  = 1000000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_cont,
    input  logic        i_stop,
    input  logic        i_cap_int,
    input  logic [31:0] i_cap_data,
    output logic        o_cap_trigger,
    output logic        o_cap_int_clr,
    output logic        o_cap_oe,
    output logic [31:0] o_result,
    output logic        o_result_valid,
    output logic        o_busy,
    output logic        o_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT,
        S_READ,
        S_LATCH,
        S_CLEAR,
        S_GAP
    } state_t;

    localparam logic [31:0] LP_TO_LAST = 32'(TIMEOUT - 1);
    localparam logic [31:0] LP_IV_LAST = 32'(INTERVAL - 1);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_cnt;
    logic        r_stop_pend;
    logic        w_to_hit;
    logic        w_gap_done;
    logic        w_to_fire;

    assign w_to_hit   = (r_cnt == LP_TO_LAST);
    assign w_gap_done = (r_cnt == LP_IV_LAST);
    // A capture interrupt on the limit cycle beats the timeout
    assign w_to_fire  = (r_state == S_WAIT) && !i_stop && !i_cap_int && w_to_hit;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (i_start && !i_stop) w_next = S_TRIG;
            end
            S_TRIG: w_next = S_WAIT;
            S_WAIT: begin
                if (i_stop)         w_next = S_CLEAR;
                else if (i_cap_int) w_next = S_READ;
                else if (w_to_hit)  w_next = S_CLEAR;
            end
            S_READ:  w_next = S_LATCH;
            S_LATCH: w_next = S_CLEAR;
            S_CLEAR: begin
                if (i_cont && !r_stop_pend && !i_stop && !o_timeout)
                    w_next = S_GAP;
                else
                    w_next = S_IDLE;
            end
            S_GAP: begin
                if (i_stop)          w_next = S_IDLE;
                else if (w_gap_done) w_next = S_TRIG;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_stop_pend   <= 1'b0;
            o_cap_trigger <= 1'b0;
            o_cap_int_clr <= 1'b0;
            o_cap_oe      <= 1'b0;
            o_busy        <= 1'b0;
            o_timeout     <= 1'b0;
        end else begin
            r_state       <= w_next;
            o_cap_trigger <= (w_next == S_TRIG);
            o_cap_oe      <= (w_next == S_READ) || (w_next == S_LATCH);
            o_cap_int_clr <= (w_next == S_CLEAR);
            o_busy        <= (w_next != S_IDLE);

            if (w_next == S_TRIG || r_state == S_CLEAR)
                r_cnt <= '0;
            else if (r_state == S_WAIT || r_state == S_GAP)
                r_cnt <= r_cnt + 32'd1;

            if (i_stop && (r_state inside {S_TRIG, S_WAIT, S_READ, S_LATCH}))
                r_stop_pend <= 1'b1;
            else if (r_state == S_IDLE || r_state == S_GAP)
                r_stop_pend <= 1'b0;

            if (r_state == S_IDLE && w_next == S_TRIG)
                o_timeout <= 1'b0;
            else if (w_to_fire)
                o_timeout <= 1'b1;
        end
    end

`ifdef PWM_CAPTURE_AVG_EN
    logic [33:0] r_acc;
    logic [1:0]  r_acc_cnt;
    logic [33:0] w_sum;

    assign w_sum = r_acc + {2'b00, i_cap_data};

    // Every path that ends a run passes through IDLE, which flushes the sum
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc          <= '0;
            r_acc_cnt      <= '0;
            o_result       <= '0;
            o_result_valid <= 1'b0;
        end else begin
            o_result_valid <= 1'b0;
            if (r_state == S_LATCH) begin
                if (r_acc_cnt == 2'd3) begin
                    o_result       <= w_sum[33:2];
                    o_result_valid <= 1'b1;
                    r_acc          <= '0;
                    r_acc_cnt      <= '0;
                end else begin
                    r_acc     <= w_sum;
                    r_acc_cnt <= r_acc_cnt + 2'd1;
                end
            end else if (r_state == S_IDLE || w_next == S_IDLE) begin
                r_acc     <= '0;
                r_acc_cnt <= '0;
            end
        end
    end
`else
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_result       <= '0;
            o_result_valid <= 1'b0;
        end else begin
            o_result_valid <= (r_state == S_LATCH);
            if (r_state == S_LATCH)
                o_result <= i_cap_data;
        end
    end
`endif

endmodule

// File: doc/pwm_capture_ctrl.md
# pwm_capture_ctrl

Sequencer for one PWM capture core. Issues capture triggers on request or periodically, waits for the core's capture interrupt with a timeout, reads the 32-bit capture word through the core's output enable, clears the interrupt, and presents the result to the host logic as a registered word with a one-cycle valid strobe. Sits between the host-side control logic and the capture core, replacing direct switch/button control of `trigger`, `int_clr` and `oe`.

## Interface
- `INTERVAL`, 100000: idle cycles between end of one capture and next trigger in continuous mode (≥1).
- `TIMEOUT`, 1000000: maximum WAIT cycles before abandoning a capture (≥2).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: pulse; starts a capture (or a continuous run if `cont`=1).
- `cont` in 1: level; sampled in CLEAR, 1 = rearm after GAP.
- `stop` in 1: pulse; aborts run.
- `cap_int` in 1: core capture interrupt flag.
- `cap_data` in 32: core capture word, valid while `cap_oe`=1.
- `cap_trigger` out 1: one-cycle capture start to core.
- `cap_int_clr` out 1: one-cycle interrupt clear to core.
- `cap_oe` out 1: core output enable.
- `result` out 32: last reported capture value.
- `result_valid` out 1: one-cycle strobe, `result` updated same cycle.
- `busy` out 1: state ≠ IDLE.
- `timeout` out 1: sticky, set on timeout, cleared by accepted `start`.

## Operation
- States: IDLE, TRIG, WAIT, READ, LATCH, CLEAR, GAP.
- IDLE: `start`=1 and `stop`=0 → TRIG, clear `timeout`. `start` and `stop` together: stay IDLE.
- TRIG: `cap_trigger`=1; zero 32-bit cycle counter → WAIT.
- WAIT: counter increments. `cap_int`=1 → READ. Else counter = TIMEOUT−1 → CLEAR, set `timeout`. Both same cycle: `cap_int` wins, no timeout. `stop` → CLEAR (no result).
- READ: `cap_oe`=1 → LATCH.
- LATCH: `cap_oe`=1; `cap_data` registered at end of cycle → CLEAR.
- CLEAR: `cap_int_clr`=1; if entered from LATCH, `result`/`result_valid` per Configuration. Next: `cont`=1 and no `stop` since last trigger and no timeout → GAP (counter zeroed), else IDLE.
- GAP: counter increments; counter = INTERVAL−1 → TRIG. `stop` → IDLE. `start` ignored.
- `start` in any non-IDLE state ignored. `stop` in TRIG/READ/LATCH latched, honoured at CLEAR (→ IDLE, result still reported).
- Reset (any time, asynchronously): state IDLE; all outputs 0, including `result` and `timeout`; counters and accumulator cleared.

## Timing
- `start` high at edge n → `cap_trigger` high cycle n+1, exactly one cycle.
- `cap_int` sampled high at edge k → `cap_oe` high cycles k+1..k+2, `cap_int_clr` and `result_valid` high cycle k+3, `busy` low cycle k+4 (single shot).
- Timeout: entering WAIT at cycle w, no `cap_int` → CLEAR at cycle w+TIMEOUT.
- Continuous period with `cap_int` on the L-th WAIT cycle: L+4+INTERVAL cycles trigger-to-trigger.
- All outputs registered; no combinational input→output paths.

## Configuration
- `PWM_CAPTURE_AVG_EN` defined: 34-bit accumulator sums four successful captures; `result` = sum[33:2] (truncated), `result_valid` only on the 4th CLEAR; count and accumulator reset on timeout, `stop`, accepted `start`.
- Undefined: every successful capture reported directly, `result` = registered `cap_data`; no accumulator logic.

## Test plan
- Single shot: `start`, model asserts `cap_int` 50 cycles after `cap_trigger` with `cap_data`=0x0001_2345 → one `cap_trigger` pulse, `result`=0x0001_2345, `result_valid` and `cap_int_clr` 3 cycles after `cap_int`, `busy` low next cycle.
- Timeout, TIMEOUT=100: no `cap_int` → `timeout`=1 and `cap_int_clr` pulse 100 cycles after WAIT entry, no `result_valid`; next `start` clears `timeout`.
- Continuous, INTERVAL=20, `cap_int` on 10th WAIT cycle: triggers every 34 cycles; `stop` in GAP → IDLE, no further triggers.
- `cap_int` on the same cycle as the timeout limit → result reported, `timeout` stays 0.
- `rst` asserted mid-WAIT → all outputs 0 before next clock edge; subsequent `start` completes normally.
- With `PWM_CAPTURE_AVG_EN`, continuous, captures 100,200,300,401 → single `result_valid`, `result`=250.
